// File: rtl/dac_spi_tx.sv
// dac_spi_tx: serialises 10-bit samples into 16-bit MCP4911-style SPI write frames.
//
// Optional feature macro: DAC_LDAC_EN
//   defined     - an LDAC state follows each frame; dac_ld_n pulses low for CLK_DIV cycles
//   not defined - no LDAC state; dac_ld_n is tied low and the DAC updates on cs_n rising
//
// Parameters
//   CLK_DIV   sysclk cycles per SCK half-period (H, >= 1)
//   DAC_BUF   frame bit 14 (VREF buffer enable)
//   DAC_GA_N  frame bit 13 (1 = 1x gain)
//
// Ports
//   sysclk    in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   data_in   in   10-bit offset-binary sample
//   load      in   1-cycle strobe, data_in valid
//   dac_cs_n  out  SPI chip select, active low
//   dac_sck   out  SPI clock, idles low
//   dac_sdi   out  SPI data, MSB first
//   dac_ld_n  out  DAC latch strobe, active low
//   busy      out  frame in progress
//   done      out  1-cycle pulse when the FSM returns to idle
module dac_spi_tx #(
   parameter int CLK_DIV  = 25,
   parameter int DAC_BUF  = 0,
   parameter int DAC_GA_N = 1
) (
   input  logic       sysclk,
   input  logic       reset,
   input  logic [9:0] data_in,
   input  logic       load,
   output logic       dac_cs_n,
   output logic       dac_sck,
   output logic       dac_sdi,
   output logic       dac_ld_n,
   output logic       busy,
   output logic       done
);

   localparam int HW = $clog2(CLK_DIV + 1);
   localparam logic [HW-1:0] H_LAST = HW'(CLK_DIV - 1);

`ifdef DAC_LDAC_EN
   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, LDAC} state_t;
`else
   typedef enum logic [1:0] {IDLE, SETUP, SHIFT} state_t;
   assign dac_ld_n = 1'b0;
`endif

   state_t          state;
   logic [HW-1:0]   hcnt;
   logic [4:0]      bcnt;
   logic [15:0]     sr;
   logic            pend;
   logic [9:0]      pend_data;
   logic            h_end;

   assign h_end = hcnt == H_LAST;

   function automatic logic [15:0] frame(input logic [9:0] d);
      return {1'b0, 1'(DAC_BUF), 1'(DAC_GA_N), 1'b1, d, 2'b00};
   endfunction

   always_ff @(posedge sysclk) begin
      if (reset) begin
         state     <= IDLE;
         hcnt      <= '0;
         bcnt      <= '0;
         sr        <= '0;
         pend      <= 1'b0;
         pend_data <= '0;
         dac_cs_n  <= 1'b1;
         dac_sck   <= 1'b0;
         dac_sdi   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef DAC_LDAC_EN
         dac_ld_n  <= 1'b1;
`endif
      end else begin
         done <= 1'b0;
         hcnt <= h_end ? '0 : hcnt + 1'b1;
         case (state)
            IDLE: begin
               hcnt <= '0;
               bcnt <= '0;
               // sdi presents frame[15] during SETUP; sr holds the remaining bits MSB-aligned
               if (pend || load) begin
                  {dac_sdi, sr} <= {frame(pend ? pend_data : data_in), 1'b0};
                  dac_cs_n      <= 1'b0;
                  busy          <= 1'b1;
                  state         <= SETUP;
               end
               // a pending sample wins; a simultaneous load becomes the new pending one
               if (pend) begin
                  pend <= load;
                  if (load) pend_data <= data_in;
               end
            end
            SETUP: if (h_end) state <= SHIFT;
            SHIFT: if (h_end) begin
               if (!dac_sck) dac_sck <= 1'b1;
               else begin
                  dac_sck <= 1'b0;
                  if (bcnt == 5'd15) begin
                     dac_cs_n <= 1'b1;
`ifdef DAC_LDAC_EN
                     dac_ld_n <= 1'b0;
                     state    <= LDAC;
`else
                     busy     <= 1'b0;
                     done     <= 1'b1;
                     state    <= IDLE;
`endif
                  end else begin
                     {dac_sdi, sr} <= {sr, 1'b0};
                     bcnt          <= bcnt + 5'd1;
                  end
               end
            end
`ifdef DAC_LDAC_EN
            LDAC: if (h_end) begin
               dac_ld_n <= 1'b1;
               busy     <= 1'b0;
               done     <= 1'b1;
               state    <= IDLE;
            end
`endif
            default: state <= IDLE;
         endcase
         // busy is high exactly outside IDLE; newest in-flight sample overwrites older
         if (busy && load) begin
            pend      <= 1'b1;
            pend_data <= data_in;
         end
      end
   end

endmodule
